// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard sequencer.
//   hz_state_t  : sequencer FSM states (RUN, MEM_WAIT, ERROR)
//   MEM_NONE    : MEM-stage command encoding meaning "no data-memory access"
//   raw_hazard(): load-use (read-after-write on a load) detection between ID and EX
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERROR    = 2'd2
  } hz_state_t;

  // Matches the MEM_NONE encoding used by the core's system definitions.
  localparam logic [3:0] MEM_NONE = 4'h0;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  function automatic logic raw_hazard(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2,
    input logic [4:0] ex_rd,
    input logic       ex_is_load,
    input logic       ex_vld
  );
    logic dep;
    dep = (use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd));
    return ex_vld & ex_is_load & (ex_rd != 5'd0) & dep;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the 5-stage pipeline and the hazard sequencer.
//   master : pipeline side, drives stage status (ID_*, ID_EX_*, EX_*, EX_MEM_*, DM_ready)
//            and receives stage controls (ST_*) and performance counters (PERF_*).
//   slave  : hazard sequencer side, the mirror image.
// Parameter CNT_W sets the performance counter width.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic [4:0]       ID_EX_rd;
  logic             ID_EX_is_load;
  logic             ID_EX_vld;
  logic             EX_take_br;
  logic [3:0]       EX_MEM_mem_cmd;
  logic             EX_MEM_vld;
  logic             DM_ready;

  logic             ST_if_id_en;
  logic             ST_id_ex_en;
  logic             ST_ex_mem_en;
  logic             ST_mem_wb_en;
  logic             ST_br_stall;
  logic             ST_if_id_flush;
  logic             ST_id_ex_flush;
  logic             ST_err;
  logic [CNT_W-1:0] PERF_lu_cnt;
  logic [CNT_W-1:0] PERF_flush_cnt;
  logic [CNT_W-1:0] PERF_memw_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
    output ID_EX_rd, ID_EX_is_load, ID_EX_vld, EX_take_br,
    output EX_MEM_mem_cmd, EX_MEM_vld, DM_ready,
    input  ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en,
    input  ST_br_stall, ST_if_id_flush, ST_id_ex_flush, ST_err,
    input  PERF_lu_cnt, PERF_flush_cnt, PERF_memw_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
    input  ID_EX_rd, ID_EX_is_load, ID_EX_vld, EX_take_br,
    input  EX_MEM_mem_cmd, EX_MEM_vld, DM_ready,
    output ST_if_id_en, ST_id_ex_en, ST_ex_mem_en, ST_mem_wb_en,
    output ST_br_stall, ST_if_id_flush, ST_id_ex_flush, ST_err,
    output PERF_lu_cnt, PERF_flush_cnt, PERF_memw_cnt
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: single saturating event counter.
//   clk, rst : clock, asynchronous active-high reset (clears the count)
//   inc      : count one event this cycle
//   cnt      : current count, sticks at all-ones
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline sequencer for the 5-stage core.
//   Resolves load-use stalls, taken-branch flushes and data-memory waits, with a
//   watchdog that latches ST_err when DM stays busy for MEM_TIMEOUT cycles.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   hz   : hazard_ctrl_if.slave (stage status in, stage enables/flushes/PC hold,
//          sticky error and performance counters out)
// Parameters: MEM_TIMEOUT (>=2) watchdog limit, CNT_W perf counter width.
// Build option: define HAZARD_PERF_CNT_EN to instantiate the three saturating
//   performance counters; otherwise PERF_* are constant zero.
//
// state       | meaning
// HZ_RUN      | normal issue, branch/load-use rules apply
// HZ_MEM_WAIT | pipeline frozen on an outstanding DM access
// HZ_ERROR    | DM watchdog expired, pipeline held until reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic mem_req;
  logic in_err;
  logic freeze;
  logic br_take;
  logic lu_stall;

  logic if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic br_stall, if_id_flush, id_ex_flush, err;

  assign mem_req = hz.EX_MEM_vld & (hz.EX_MEM_mem_cmd != MEM_NONE);
  assign in_err  = (state_q == HZ_ERROR);
  assign freeze  = ~in_err & mem_req & ~hz.DM_ready;
  assign br_take = ~in_err & ~freeze & hz.EX_take_br & hz.ID_EX_vld;
  // Branch outranks load-use: the dependent ID instruction is being flushed anyway.
  assign lu_stall = ~in_err & ~freeze & ~br_take &
                    raw_hazard(hz.ID_rs1, hz.ID_rs2, hz.ID_use_rs1, hz.ID_use_rs2,
                               hz.ID_EX_rd, hz.ID_EX_is_load, hz.ID_EX_vld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // The wait count is the number of consecutive frozen cycles including this one;
  // the edge that completes the MEM_TIMEOUT-th frozen cycle enters ERROR.
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    case (state_q)
      HZ_RUN, HZ_MEM_WAIT: begin
        if (freeze) begin
          wcnt_d  = wcnt_q + 1'b1;
          state_d = (wcnt_d == WCNT_W'(MEM_TIMEOUT)) ? HZ_ERROR : HZ_MEM_WAIT;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_ERROR: state_d = HZ_ERROR;
      default:  state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    br_stall    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    err         = 1'b0;
    if (in_err || freeze) begin
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      br_stall  = 1'b1;
      err       = in_err;
    end else if (br_take) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_stall) begin
      // Hold IF/ID and PC, inject one bubble into ID/EX; the bubble clears
      // ID_EX_vld next cycle so the stall lasts exactly one cycle.
      if_id_en    = 1'b0;
      br_stall    = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign hz.ST_if_id_en    = if_id_en;
  assign hz.ST_id_ex_en    = id_ex_en;
  assign hz.ST_ex_mem_en   = ex_mem_en;
  assign hz.ST_mem_wb_en   = mem_wb_en;
  assign hz.ST_br_stall    = br_stall;
  assign hz.ST_if_id_flush = if_id_flush;
  assign hz.ST_id_ex_flush = id_ex_flush;
  assign hz.ST_err         = err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt, flush_cnt, memw_cnt;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk (clk), .rst (rst), .inc (lu_stall), .cnt (lu_cnt)
  );
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .inc (br_take), .cnt (flush_cnt)
  );
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_memw_cnt (
    .clk (clk), .rst (rst), .inc (freeze), .cnt (memw_cnt)
  );

  assign hz.PERF_lu_cnt    = lu_cnt;
  assign hz.PERF_flush_cnt = flush_cnt;
  assign hz.PERF_memw_cnt  = memw_cnt;
`else
  assign hz.PERF_lu_cnt    = '0;
  assign hz.PERF_flush_cnt = '0;
  assign hz.PERF_memw_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=2).
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 2;
  localparam int PERF_MAX    = (1 << CNT_W) - 1;

  // Output vector order: if_id_en id_ex_en ex_mem_en mem_wb_en br_stall if_id_flush id_ex_flush err
  localparam logic [7:0] O_NORM   = 8'b1111_0000;
  localparam logic [7:0] O_LU     = 8'b0111_1010;
  localparam logic [7:0] O_BR     = 8'b1111_0110;
  localparam logic [7:0] O_FREEZE = 8'b0000_1000;
  localparam logic [7:0] O_ERR    = 8'b0000_1001;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       ld;
    logic       exv;
    logic       br;
    logic [3:0] cmd;
    logic       mv;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // reference model state
  bit m_err;
  int m_wait, m_lu, m_fl, m_mw;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  function automatic in_t idle_in();
    in_t x;
    x.rs1 = 5'd0; x.rs2 = 5'd0; x.use1 = 1'b0; x.use2 = 1'b0;
    x.rd = 5'd0; x.ld = 1'b0; x.exv = 1'b0; x.br = 1'b0;
    x.cmd = 4'h0; x.mv = 1'b0; x.rdy = 1'b1;
    return x;
  endfunction

  task automatic drive(input in_t x);
    hz.ID_rs1 = x.rs1; hz.ID_rs2 = x.rs2;
    hz.ID_use_rs1 = x.use1; hz.ID_use_rs2 = x.use2;
    hz.ID_EX_rd = x.rd; hz.ID_EX_is_load = x.ld; hz.ID_EX_vld = x.exv;
    hz.EX_take_br = x.br; hz.EX_MEM_mem_cmd = x.cmd; hz.EX_MEM_vld = x.mv;
    hz.DM_ready = x.rdy;
  endtask

  function automatic logic [7:0] dut_out();
    return {hz.ST_if_id_en, hz.ST_id_ex_en, hz.ST_ex_mem_en, hz.ST_mem_wb_en,
            hz.ST_br_stall, hz.ST_if_id_flush, hz.ST_id_ex_flush, hz.ST_err};
  endfunction

  function automatic logic [31:0] dut_perf();
    return (32'(hz.PERF_lu_cnt) << 16) | (32'(hz.PERF_flush_cnt) << 8) | 32'(hz.PERF_memw_cnt);
  endfunction

  function automatic logic [31:0] perf_word(input int lu, input int fl, input int mw);
`ifdef HAZARD_PERF_CNT_EN
    return (32'(lu) << 16) | (32'(fl) << 8) | 32'(mw);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: classify the cycle from the rules, in priority order.
  function automatic bit is_frozen(input in_t x);
    return !m_err && x.mv && (x.cmd != 4'h0) && !x.rdy;
  endfunction

  function automatic bit is_branch(input in_t x);
    return !m_err && !is_frozen(x) && x.br && x.exv;
  endfunction

  function automatic bit is_loaduse(input in_t x);
    bit dep;
    dep = (x.use1 && x.rs1 == x.rd) || (x.use2 && x.rs2 == x.rd);
    return !m_err && !is_frozen(x) && !is_branch(x) && x.exv && x.ld && (x.rd != 0) && dep;
  endfunction

  function automatic logic [7:0] model_out(input in_t x);
    if (m_err)         return O_ERR;
    if (is_frozen(x))  return O_FREEZE;
    if (is_branch(x))  return O_BR;
    if (is_loaduse(x)) return O_LU;
    return O_NORM;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < PERF_MAX) ? v + 1 : v;
  endfunction

  task automatic model_clock(input in_t x);
    if (is_frozen(x)) begin
      m_mw = sat_inc(m_mw);
      m_wait++;
      if (m_wait >= MEM_TIMEOUT) m_err = 1'b1;
    end else begin
      if (is_branch(x))  m_fl = sat_inc(m_fl);
      if (is_loaduse(x)) m_lu = sat_inc(m_lu);
      m_wait = 0;
    end
  endtask

  task automatic model_reset();
    m_err = 1'b0; m_wait = 0; m_lu = 0; m_fl = 0; m_mw = 0;
  endtask

  // Called just after a negedge: apply inputs, check, then advance one clock.
  task automatic step(input in_t x, input logic [7:0] exp, input string nm);
    drive(x);
    #1;
    chk(nm, 32'(dut_out()), 32'(exp));
    chk({nm, "_perf"}, dut_perf(), perf_word(m_lu, m_fl, m_mw));
    @(posedge clk);
    model_clock(x);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(idle_in());
    model_reset();
    #1;
    chk("reset_out", 32'(dut_out()), 32'(O_NORM));
    chk("reset_perf", dut_perf(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[$];
  in_t  x;

  initial begin
    model_reset();
    drive(idle_in());

    // ---- table-driven single-cycle vectors ----
    x = idle_in();                                         tbl.push_back('{x, O_NORM, "idle"});
    x = idle_in(); x.rs2 = 5; x.use2 = 1; x.rd = 5; x.ld = 1; x.exv = 1;
                                                           tbl.push_back('{x, O_LU, "lu_rs2"});
    x = idle_in(); x.rs1 = 0; x.use1 = 1; x.rd = 0; x.ld = 1; x.exv = 1;
                                                           tbl.push_back('{x, O_NORM, "lu_rd0"});
    x = idle_in(); x.rs1 = 7; x.use1 = 0; x.rd = 7; x.ld = 1; x.exv = 1;
                                                           tbl.push_back('{x, O_NORM, "lu_nouse"});
    x = idle_in(); x.rs1 = 9; x.use1 = 1; x.rd = 9; x.ld = 0; x.exv = 1;
                                                           tbl.push_back('{x, O_NORM, "not_load"});
    x = idle_in(); x.rs1 = 9; x.use1 = 1; x.rd = 9; x.ld = 1; x.exv = 0;
                                                           tbl.push_back('{x, O_NORM, "ex_invalid"});
    x = idle_in(); x.rs1 = 31; x.use1 = 1; x.rd = 31; x.ld = 1; x.exv = 1;
                                                           tbl.push_back('{x, O_LU, "lu_rs1"});
    x = idle_in(); x.br = 1; x.exv = 1;                    tbl.push_back('{x, O_BR, "branch"});
    x = idle_in(); x.br = 1; x.exv = 1; x.rs2 = 3; x.use2 = 1; x.rd = 3; x.ld = 1;
                                                           tbl.push_back('{x, O_BR, "branch_over_lu"});
    x = idle_in(); x.br = 1; x.exv = 0;                    tbl.push_back('{x, O_NORM, "branch_invalid"});
    x = idle_in(); x.br = 1; x.exv = 1; x.cmd = 4'h3; x.mv = 1; x.rdy = 0;
                                                           tbl.push_back('{x, O_FREEZE, "freeze_br"});
    x = idle_in(); x.cmd = 4'h3; x.mv = 1; x.rdy = 1;      tbl.push_back('{x, O_NORM, "mem_ready"});
    x = idle_in(); x.cmd = 4'h0; x.mv = 1; x.rdy = 0;      tbl.push_back('{x, O_NORM, "mem_none"});
    x = idle_in(); x.cmd = 4'h2; x.mv = 0; x.rdy = 0;      tbl.push_back('{x, O_NORM, "mem_invalid"});
    x = idle_in(); x.cmd = 4'h1; x.mv = 1; x.rdy = 0; x.rs1 = 4; x.use1 = 1; x.rd = 4; x.ld = 1; x.exv = 1;
                                                           tbl.push_back('{x, O_FREEZE, "freeze_lu"});
    x = idle_in(); x.cmd = 4'h1; x.mv = 1; x.rdy = 1; x.rs1 = 4; x.use1 = 1; x.rd = 4; x.ld = 1; x.exv = 1;
                                                           tbl.push_back('{x, O_LU, "ready_then_lu"});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].i, tbl[i].exp, tbl[i].nm);
    end

    // ---- DM wait: 3 frozen cycles with a pending branch, then release ----
    do_reset();
    x = idle_in(); x.rs2 = 5; x.use2 = 1; x.rd = 5; x.ld = 1; x.exv = 1;
    step(x, O_LU, "seq_lu");
    x = idle_in(); x.exv = 1; step(x, O_NORM, "seq_lu_bubble_gone");
    x = idle_in(); x.br = 1; x.exv = 1; step(x, O_BR, "seq_br");
    x = idle_in(); x.br = 1; x.exv = 1; x.cmd = 4'h2; x.mv = 1; x.rdy = 0;
    for (int i = 0; i < 3; i++) step(x, O_FREEZE, "seq_freeze");
    x = idle_in(); x.cmd = 4'h2; x.mv = 1; x.rdy = 1; step(x, O_NORM, "seq_release");
    chk("perf_after_seq", dut_perf(), perf_word(1, 1, 3));
    // two more frozen cycles push memw past the 2-bit range
    x = idle_in(); x.cmd = 4'h2; x.mv = 1; x.rdy = 0;
    for (int i = 0; i < 2; i++) step(x, O_FREEZE, "seq_freeze_more");
    x = idle_in(); step(x, O_NORM, "seq_release2");
    chk("perf_saturated", dut_perf(), perf_word(1, 1, 3));

    // ---- watchdog: DM_ready held low for MEM_TIMEOUT cycles ----
    do_reset();
    x = idle_in(); x.cmd = 4'h5; x.mv = 1; x.rdy = 0; x.br = 1; x.exv = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) step(x, O_FREEZE, "wd_frozen");
    step(x, O_ERR, "wd_error");
    x = idle_in(); x.br = 1; x.exv = 1;
    step(x, O_ERR, "wd_sticky_br");
    x = idle_in();
    step(x, O_ERR, "wd_sticky_idle");
    #2 rst = 1'b1;
    #1;
    chk("wd_async_rst", 32'(dut_out()), 32'(O_NORM));
    chk("wd_async_rst_perf", dut_perf(), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(x, O_NORM, "wd_after_rst");

    // ---- randomized stimulus against the reference model ----
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_err && ($urandom_range(0, 3) == 0)) do_reset();
      x.rs1  = 5'($urandom_range(0, 3));
      x.rs2  = 5'($urandom_range(0, 3));
      x.use1 = 1'($urandom_range(0, 1));
      x.use2 = 1'($urandom_range(0, 1));
      x.rd   = 5'($urandom_range(0, 3));
      x.ld   = 1'($urandom_range(0, 1));
      x.exv  = ($urandom_range(0, 3) != 0);
      x.br   = ($urandom_range(0, 4) == 0);
      x.cmd  = 4'($urandom_range(0, 3));
      x.mv   = 1'($urandom_range(0, 1));
      x.rdy  = ($urandom_range(0, 2) != 0);
      step(x, model_out(x), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
